// File: rtl/nco_sweep_ctrl.sv
// Chirp controller feeding the NCO phase increment: steps delta_index_o from a
// start value toward a stop value with a per-step dwell, with single, sawtooth or triangle end-of-sweep handling.
module nco_sweep_ctrl #(
  parameter int unsigned DWELL_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [1:0]           mode_i,
  input  logic signed [31:0]   f_start_i,
  input  logic signed [31:0]   f_stop_i,
  input  logic [31:0]          f_step_i,
  input  logic [DWELL_W-1:0]   dwell_i,
  output logic signed [31:0]   delta_index_o,
  output logic                 valid_o,
  output logic                 busy_o,
  output logic                 end_o
);

  localparam int unsigned FW = 32;
  localparam int unsigned AW = 33;

  localparam logic [1:0] MODE_SAW = 2'b01;
  localparam logic [1:0] MODE_TRI = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_HOLD} state_e;

  state_e                    state_q, state_d;
  logic signed [FW-1:0]      val_q, val_d;
  logic                      dir_up_q, dir_up_d;
  logic [DWELL_W-1:0]        cnt_q, cnt_d;
  logic [DWELL_W-1:0]        dwell_m1_q, dwell_m1_d;
  logic [1:0]                mode_q, mode_d;
  logic signed [FW-1:0]      f_start_q, f_start_d;
  logic signed [FW-1:0]      f_stop_q, f_stop_d;
  logic [FW-1:0]             f_step_q, f_step_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;
  logic                      end_q, end_d;
  logic signed [FW-1:0]      cur_tgt;

  // Target end for a direction: the upper end when moving up, the lower end otherwise.
  function automatic logic signed [FW-1:0] target_of(input logic up,
                                                     input logic signed [FW-1:0] a,
                                                     input logic signed [FW-1:0] b);
    logic signed [FW-1:0] hi, lo;
    hi = (a >= b) ? a : b;
    lo = (a >= b) ? b : a;
    return up ? hi : lo;
  endfunction

  // One step toward tgt; the remaining distance is a non-negative 33-bit value, so the step never overshoots or wraps.
  function automatic logic signed [FW-1:0] step_toward(input logic signed [FW-1:0] val,
                                                       input logic signed [FW-1:0] tgt,
                                                       input logic up,
                                                       input logic [FW-1:0] step);
    logic [AW-1:0] rem;
    rem = up ? AW'(AW'(tgt) - AW'(val)) : AW'(AW'(val) - AW'(tgt));
    if ({1'b0, step} >= rem) return tgt;
    return up ? FW'(val + step) : FW'(val - step);
  endfunction

  assign cur_tgt = target_of(dir_up_q, f_start_q, f_stop_q);

  always_comb begin
    state_d    = state_q;
    val_d      = val_q;
    dir_up_d   = dir_up_q;
    cnt_d      = cnt_q;
    dwell_m1_d = dwell_m1_q;
    mode_d     = mode_q;
    f_start_d  = f_start_q;
    f_stop_d   = f_stop_q;
    f_step_d   = f_step_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_SWEEP;
          mode_d     = mode_i;
          f_start_d  = f_start_i;
          f_stop_d   = f_stop_i;
          f_step_d   = f_step_i;
          dwell_m1_d = (dwell_i == '0) ? '0 : DWELL_W'(dwell_i - 1'b1);
          cnt_d      = dwell_m1_d;
          dir_up_d   = (f_stop_i >= f_start_i);
          val_d      = f_start_i;
        end
      end
      S_SWEEP: begin
        if (cnt_q != '0) begin
          cnt_d = DWELL_W'(cnt_q - 1'b1);
        end else begin
          cnt_d = dwell_m1_q;
          if (val_q == cur_tgt) begin
            case (mode_q)
              MODE_SAW: val_d = f_start_q;
              MODE_TRI: begin
                dir_up_d = !dir_up_q;
                val_d    = step_toward(val_q, target_of(!dir_up_q, f_start_q, f_stop_q),
                                       !dir_up_q, f_step_q);
              end
              default: begin
                state_d = S_HOLD;
                val_d   = f_stop_q;
              end
            endcase
          end else begin
            val_d = step_toward(val_q, cur_tgt, dir_up_q, f_step_q);
          end
        end
      end
      default: ;
    endcase

    if (stop_i) begin
      state_d  = S_IDLE;
      val_d    = '0;
      dir_up_d = 1'b0;
      cnt_d    = '0;
    end

    // Predict whether the coming cycle is the last dwell cycle at the target.
    valid_d = (state_d != S_IDLE);
    busy_d  = (state_d == S_SWEEP);
    end_d   = (state_d == S_SWEEP) && (cnt_d == '0) &&
              (val_d == target_of(dir_up_d, f_start_d, f_stop_d));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      val_q      <= '0;
      dir_up_q   <= 1'b0;
      cnt_q      <= '0;
      dwell_m1_q <= '0;
      mode_q     <= '0;
      f_start_q  <= '0;
      f_stop_q   <= '0;
      f_step_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      end_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      val_q      <= val_d;
      dir_up_q   <= dir_up_d;
      cnt_q      <= cnt_d;
      dwell_m1_q <= dwell_m1_d;
      mode_q     <= mode_d;
      f_start_q  <= f_start_d;
      f_stop_q   <= f_stop_d;
      f_step_q   <= f_step_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      end_q      <= end_d;
    end
  end

  assign delta_index_o = val_q;
  assign valid_o       = valid_q;
  assign busy_o        = busy_q;
  assign end_o         = end_q;

endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
Frequency-sweep (chirp) controller placed directly upstream of the NCO top. It generates the signed 32-bit phase increment and its qualifying valid for the NCO's delta_index_i/valid_i inputs. It steps the increment from a start value toward a stop value, in fixed increments, with a programmable dwell time per step. Three end-of-sweep policies are supported: single, sawtooth repeat and triangle.

Parameters:
DWELL_W, 16, width of dwell_i and of the internal dwell counter.

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
start_i  input  1  start sweep; sampled only in IDLE
stop_i  input  1  abort; returns to IDLE from any state
mode_i  input  2  00 single, 01 sawtooth repeat, 10 triangle, 11 treated as single
f_start_i  input  32  signed start increment
f_stop_i  input  32  signed stop increment
f_step_i  input  32  step magnitude, unsigned
dwell_i  input  DWELL_W  clocks each value is held; 0 treated as 1
delta_index_o  output  32  signed increment to NCO (delta_index_i)
valid_o  output  1  increment valid to NCO (valid_i)
busy_o  output  1  high in SWEEP
end_o  output  1  one-cycle pulse at each end-point event

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE. delta_index_o=0, valid_o=0, busy_o=0, end_o=0. Direction, dwell counter and all config registers are cleared.
- States:
  - IDLE: outputs 0.
  - SWEEP: valid_o=1, busy_o=1.
  - HOLD: valid_o=1, busy_o=0, delta_index_o frozen at f_stop.
- Transitions:
  - start_i in IDLE at edge N: mode, f_start, f_stop, f_step and dwell are latched. At N+1, state=SWEEP and delta_index_o=f_start.
  - start_i outside IDLE is ignored.
  - Config inputs are ignored after the latch edge.
- stop_i wins over start_i and over any sweep event. It forces IDLE and zero outputs at the next edge from any state; no end_o is generated.
- Dwell: each output value is held for exactly max(dwell,1) cycles. The counter reloads on every value change.
- Direction:
  - dir=up if f_stop >= f_start (signed compare), else down.
  - Next value = current +/- f_step, toward the current target.
  - Arithmetic is 33-bit signed. If the result passes the target, it is clamped to the target.
  - There is no 32-bit wrap under any input.
- End-point event: occurs on the last dwell cycle of a value equal to the current target. end_o=1 in that cycle. Then, per mode:
  - single: next cycle HOLD with f_stop.
  - sawtooth: next value = f_start; direction and target are unchanged.
  - triangle: direction flips, and the target becomes the other end. The next value is the target ± step, clamped. Turns happen at both ends; end_o pulses at each turn.
- f_start == f_stop:
  - Value is constant.
  - An end event occurs every dwell period, with the mode action applied.
  - Triangle with equal ends keeps the same value.
- f_step = 0: the value never changes and no end event occurs unless f_start == f_stop.
- HOLD persists until stop_i; start_i in HOLD is ignored.
- Latency: start edge to first valid increment is 1 cycle. All outputs are registered with no combinational input-to-output paths.

Test Plan:
- Reset, then idle 5 cycles -> delta_index_o=0, valid_o=0, busy_o=0, end_o=0 every cycle.
- Single sweep: f_start=100, f_stop=130, step=10, dwell=2, start pulse at edge N.
  - Expected output: 100,100,110,110,120,120,130,130 from N+1.
  - end_o high on the 2nd cycle of 130.
  - Then HOLD: 130, valid=1, busy=0, until stop; output 0 the cycle after stop.
- Clamp, down direction: f_start=0, f_stop=-25, step=10, dwell=1.
  - Expected output: 0,-10,-20,-25, then HOLD at -25.
  - end_o pulses in the -25 cycle.
- Sawtooth: 0→20, step 10, dwell=1 -> 0,10,20,0,10,20,...; end_o pulses on each 20.
- Triangle: 0→20, step 10, dwell=1 -> 0,10,20,10,0,10,20,...; end_o pulses on each 20 and each turning 0 after the first.
- Edge cases:
  - dwell_i=0 behaves as dwell=1.
  - stop_i and start_i together in IDLE -> stays IDLE.
  - stop_i mid-sweep -> IDLE next cycle, no end_o.
  - rst mid-sweep -> all outputs 0 next cycle.
  - Changing f_* inputs during SWEEP has no effect.
